// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end feeding {pc, instr} pairs to decode through a small FIFO
module fetch_unit #(
  parameter int N     = 32,
  parameter int AW    = 6,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [N-1:0]  imem_q,
  input  logic          redirect_valid,
  input  logic [63:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_instr,
  output logic [63:0]   out_pc,
  output logic [31:0]   fetch_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [N-1:0]  instr_mem [DEPTH];
  logic [63:0]   pc_mem [DEPTH];
  logic [N-1:0]  out_instr_q, out_instr_d;
  logic [63:0]   out_pc_q, out_pc_d;
  logic [31:0]   fetch_count_q, fetch_count_d;
  logic          push, pop, bypass;
  always_comb begin
    pop           = (cnt_q != '0) & out_ready;
    push          = !redirect_valid & ((cnt_q < FULL) | pop);
    rd_d          = redirect_valid ? '0 : rd_q + PW'(pop);
    wr_d          = redirect_valid ? '0 : wr_q + PW'(push);
    cnt_d         = redirect_valid ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    fetch_pc_d    = redirect_valid ? (redirect_pc & ~64'd3) : fetch_pc_q + (push ? 64'd4 : 64'd0);
    fetch_count_d = fetch_count_q + 32'(pop);
    // the new head is the word being fetched right now when the FIFO would otherwise be empty
    bypass        = push & (wr_q == rd_d);
    out_instr_d   = (cnt_d == '0) ? out_instr_q : bypass ? imem_q : instr_mem[rd_d];
    out_pc_d      = (cnt_d == '0) ? out_pc_q : bypass ? fetch_pc_q : pc_mem[rd_d];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
      cnt_q         <= '0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      fetch_count_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      cnt_q         <= cnt_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      fetch_count_q <= fetch_count_d;
      if (push) begin
        instr_mem[wr_q] <= imem_q;
        pc_mem[wr_q]    <= fetch_pc_q;
      end
    end
  end
  assign imem_addr   = fetch_pc_q[AW+1:2];
  assign out_valid   = cnt_q != '0;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a small imem image
module tb_fetch_unit;
  logic        clk = 0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [31:0] fetch_count;
  logic [31:0] img [64];
  int checks = 0;
  int failures = 0;

  fetch_unit #(.N(32), .AW(6), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  always_comb imem_q = img[imem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic [63:0] pc, input logic [31:0] instr);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, 64'(out_instr), 64'(instr));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) img[i] = 32'h0;
    img[0] = 32'hf8000001; img[1] = 32'hf8008002; img[2] = 32'hf8000203; img[46] = 32'hb400001f;
    reset = 1; out_ready = 1; redirect_valid = 0; redirect_pc = 0;
    #1; step(); step();
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", 64'(out_instr), 0);
    chk("rst_count", 64'(fetch_count), 0);
    chk("rst_addr", 64'(imem_addr), 0);
    // basic streaming
    reset = 0;
    step(); head("s0", 64'h0, 32'hf8000001);
    step(); head("s4", 64'h4, 32'hf8008002);
    step(); head("s8", 64'h8, 32'hf8000203);
    chk("s_count", 64'(fetch_count), 2);
    // stall fills the FIFO and freezes the fetch address
    reset = 1; out_ready = 0;
    step();
    reset = 0;
    step(); head("f0", 64'h0, 32'hf8000001);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_addr", 64'(imem_addr), 2);
      head("stall_head", 64'h0, 32'hf8000001);
    end
    chk("stall_count", 64'(fetch_count), 0);
    out_ready = 1;
    step(); head("r4", 64'h4, 32'hf8008002); chk("r4_count", 64'(fetch_count), 1);
    step(); head("r8", 64'h8, 32'hf8000203); chk("r8_count", 64'(fetch_count), 2);
    step(); head("rc", 64'hc, 32'h0); chk("rc_count", 64'(fetch_count), 3);
    // redirect while full
    out_ready = 0;
    step(); step();
    redirect_valid = 1; redirect_pc = 64'hb8;
    step();
    chk("rd_valid", 64'(out_valid), 0);
    redirect_valid = 0; out_ready = 1;
    step(); head("b8", 64'hb8, 32'hb400001f);
    step(); head("bc", 64'hbc, 32'h0);
    chk("bc_count", 64'(fetch_count), 4);
    // misaligned redirect with a simultaneous pop, then address wrap
    redirect_valid = 1; redirect_pc = 64'hfa;
    step();
    chk("mis_valid", 64'(out_valid), 0);
    chk("mis_count", 64'(fetch_count), 5);
    redirect_valid = 0;
    step(); head("f8", 64'hf8, 32'h0);
    step(); head("fc", 64'hfc, 32'h0);
    chk("wrap_addr", 64'(imem_addr), 0);
    step(); head("p100", 64'h100, 32'hf8000001);
    chk("p100_count", 64'(fetch_count), 7);
    // redirect and pop together: counted once, no stale PC afterward
    redirect_valid = 1; redirect_pc = 64'h8;
    step();
    chk("rp_valid", 64'(out_valid), 0);
    chk("rp_count", 64'(fetch_count), 8);
    redirect_valid = 0;
    step(); head("rp8", 64'h8, 32'hf8000203);
    step(); head("rpc", 64'hc, 32'h0);
    chk("rpc_count", 64'(fetch_count), 9);
    // reset mid-stream
    reset = 1;
    step();
    chk("mr_valid", 64'(out_valid), 0);
    chk("mr_count", 64'(fetch_count), 0);
    chk("mr_pc", out_pc, 0);
    reset = 0;
    step(); head("mr0", 64'h0, 32'hf8000001);
    step(); head("mr4", 64'h4, 32'hf8008002);
    chk("mr4_count", 64'(fetch_count), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
